// File: rtl/elevator_ctrl.sv
// Four-floor elevator controller: latches floor calls, keeps moving in the current
// direction while calls remain ahead, and opens the door when it reaches a called floor.
module elevator_ctrl #(
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic       CK,
    input  logic       CLR,
    input  logic [3:0] REQ,
    output logic [1:0] FLOOR,
    output logic       UP,
    output logic       DOWN,
    output logic       DOOR_OPEN,
    output logic [3:0] PENDING
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } state_t;

    localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYC - 1);
    localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYC - 1);
    localparam logic       DIR_UP      = 1'b1;
    localparam logic       DIR_DN      = 1'b0;

    state_t     state, state_nxt;
    logic [1:0] floor_q, floor_nxt;
    logic [3:0] pending_q, pending_nxt;
    logic       dir_q, dir_nxt;
    logic [7:0] travel_cnt, travel_nxt;
    logic [7:0] door_cnt, door_nxt;

    logic [3:0] floor_bit;
    logic [3:0] above_mask;
    logic [3:0] below_mask;
    logic [3:0] further_up_mask;
    logic [3:0] further_dn_mask;
    logic [1:0] floor_up;
    logic [1:0] floor_dn;
    logic [3:0] door_clear;
    logic       call_above;
    logic       call_below;

    // Call masks are relative to the current floor; "further" masks look past the next floor.
    assign floor_bit       = 4'b0001 << floor_q;
    assign above_mask      = 4'b1110 << floor_q;
    assign below_mask      = ~(above_mask | floor_bit);
    assign further_up_mask = 4'b1100 << floor_q;
    assign further_dn_mask = (floor_bit >> 1) - 4'd1;
    assign floor_up        = floor_q + 2'd1;
    assign floor_dn        = floor_q - 2'd1;
    assign call_above      = |(pending_q & above_mask);
    assign call_below      = |(pending_q & below_mask);

    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            state      <= IDLE;
            floor_q    <= 2'd0;
            pending_q  <= 4'b0000;
            dir_q      <= DIR_UP;
            travel_cnt <= 8'd0;
            door_cnt   <= 8'd0;
        end else begin
            state      <= state_nxt;
            floor_q    <= floor_nxt;
            pending_q  <= pending_nxt;
            dir_q      <= dir_nxt;
            travel_cnt <= travel_nxt;
            door_cnt   <= door_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        floor_nxt  = floor_q;
        dir_nxt    = dir_q;
        travel_nxt = travel_cnt;
        door_nxt   = door_cnt;

        case (state)
            IDLE: begin
                // A call at the current floor opens the door at once, so it never latches.
                if (pending_q[floor_q] || REQ[floor_q]) begin
                    state_nxt = DOOR;
                    door_nxt  = DOOR_LOAD;
                end else if (call_above && (dir_q == DIR_UP || !call_below)) begin
                    state_nxt  = MOVE_UP;
                    dir_nxt    = DIR_UP;
                    travel_nxt = TRAVEL_LOAD;
                end else if (call_below) begin
                    state_nxt  = MOVE_DN;
                    dir_nxt    = DIR_DN;
                    travel_nxt = TRAVEL_LOAD;
                end
            end

            MOVE_UP: begin
                if (floor_q == 2'd3) begin
                    state_nxt = IDLE;
                end else if (travel_cnt != 8'd0) begin
                    travel_nxt = travel_cnt - 8'd1;
                end else begin
                    floor_nxt = floor_up;
                    if (pending_q[floor_up]) begin
                        state_nxt = DOOR;
                        door_nxt  = DOOR_LOAD;
                    end else if (|(pending_q & further_up_mask)) begin
                        travel_nxt = TRAVEL_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            MOVE_DN: begin
                if (floor_q == 2'd0) begin
                    state_nxt = IDLE;
                end else if (travel_cnt != 8'd0) begin
                    travel_nxt = travel_cnt - 8'd1;
                end else begin
                    floor_nxt = floor_dn;
                    if (pending_q[floor_dn]) begin
                        state_nxt = DOOR;
                        door_nxt  = DOOR_LOAD;
                    end else if (|(pending_q & further_dn_mask)) begin
                        travel_nxt = TRAVEL_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            DOOR: begin
                if (REQ[floor_q]) begin
                    door_nxt = DOOR_LOAD;
                end else if (door_cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    door_nxt = door_cnt - 8'd1;
                end
            end

            default: state_nxt = IDLE;
        endcase

        // Being in or entering DOOR at a floor both blocks and clears that floor's call.
        door_clear  = (state_nxt == DOOR) ? (4'b0001 << floor_nxt) : 4'b0000;
        pending_nxt = (pending_q | REQ) & ~door_clear;
    end

    assign FLOOR     = floor_q;
    assign PENDING   = pending_q;
    assign UP        = (state == MOVE_UP);
    assign DOWN      = (state == MOVE_DN);
    assign DOOR_OPEN = (state == DOOR);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl at default timing (4 cycles per floor, 3 door cycles),
// with hand-computed expected outputs after each group of clock edges.
module tb_elevator_ctrl;

    logic       CK;
    logic       CLR;
    logic [3:0] REQ;
    logic [1:0] FLOOR;
    logic       UP;
    logic       DOWN;
    logic       DOOR_OPEN;
    logic [3:0] PENDING;

    int n_checks = 0;
    int n_fail   = 0;

    elevator_ctrl #(
        .TRAVEL_CYC(4),
        .DOOR_CYC  (3)
    ) dut (
        .CK       (CK),
        .CLR      (CLR),
        .REQ      (REQ),
        .FLOOR    (FLOOR),
        .UP       (UP),
        .DOWN     (DOWN),
        .DOOR_OPEN(DOOR_OPEN),
        .PENDING  (PENDING)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Drive REQ for n rising edges, then settle 1 time unit past the last edge.
    task automatic applyStimulus(input logic [3:0] r, input int n);
        REQ = r;
        repeat (n) @(posedge CK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] f, input logic u,
                               input logic d, input logic o, input logic [3:0] p);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {FLOOR, UP, DOWN, DOOR_OPEN, PENDING};
        exp = {f, u, d, o, p};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: floor/up/down/door/pending observed %b expected %b",
                   tag, obs, exp);
        end
    endtask

    initial begin
        CLR = 1'b1;
        REQ = 4'b0000;
        @(posedge CK);
        #1;
        checkOutput("reset_state", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        CLR = 1'b0;

        // Call at the current floor: door for 3 cycles, no latching, no motion.
        applyStimulus(4'b0001, 1);
        checkOutput("own_floor_door1", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 1);
        checkOutput("own_floor_door2", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 1);
        checkOutput("own_floor_door3", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 1);
        checkOutput("own_floor_close", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Floor 0 -> 2 with a single one-cycle call.
        applyStimulus(4'b0100, 1);
        checkOutput("latch_call2", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0100);
        applyStimulus(4'b0000, 1);
        checkOutput("start_up", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0100);
        applyStimulus(4'b0000, 3);
        checkOutput("still_floor0", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0100);
        applyStimulus(4'b0000, 1);
        checkOutput("reach_floor1", 2'd1, 1'b1, 1'b0, 1'b0, 4'b0100);
        applyStimulus(4'b0000, 3);
        checkOutput("last_up_cycle", 2'd1, 1'b1, 1'b0, 1'b0, 4'b0100);
        applyStimulus(4'b0000, 1);
        checkOutput("arrive_floor2", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 2);
        checkOutput("door_floor2_end", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 1);
        checkOutput("idle_floor2", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Floor 2, direction up, calls at 3 and 0: up first, then down.
        applyStimulus(4'b1001, 1);
        checkOutput("latch_1001", 2'd2, 1'b0, 1'b0, 1'b0, 4'b1001);
        applyStimulus(4'b0000, 1);
        checkOutput("prefer_up", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
        applyStimulus(4'b0000, 4);
        checkOutput("door_floor3", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001);
        applyStimulus(4'b0000, 3);
        checkOutput("idle_floor3", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0001);
        applyStimulus(4'b0000, 1);
        checkOutput("start_down", 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001);
        applyStimulus(4'b0000, 4);
        checkOutput("pass_floor2_dn", 2'd2, 1'b0, 1'b1, 1'b0, 4'b0001);

        // Asynchronous clear mid-move, away from any clock edge.
        #2;
        CLR = 1'b1;
        #1;
        checkOutput("clr_mid_move", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        REQ = 4'b0110;
        @(posedge CK);
        #1;
        checkOutput("clr_held", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        CLR = 1'b0;
        applyStimulus(4'b1000, 1);
        checkOutput("first_edge_after_clr", 2'd0, 1'b0, 1'b0, 1'b0, 4'b1000);

        // Heading to 3, a call at 1 arrives before reaching 1: stop there, then resume.
        applyStimulus(4'b0000, 1);
        checkOutput("up_toward3", 2'd0, 1'b1, 1'b0, 1'b0, 4'b1000);
        applyStimulus(4'b0010, 1);
        checkOutput("late_call1", 2'd0, 1'b1, 1'b0, 1'b0, 4'b1010);
        applyStimulus(4'b0000, 3);
        checkOutput("stop_floor1", 2'd1, 1'b0, 1'b0, 1'b1, 4'b1000);
        applyStimulus(4'b0000, 3);
        checkOutput("idle_floor1", 2'd1, 1'b0, 1'b0, 1'b0, 4'b1000);
        applyStimulus(4'b0000, 1);
        checkOutput("resume_up", 2'd1, 1'b1, 1'b0, 1'b0, 4'b1000);
        applyStimulus(4'b0000, 4);
        checkOutput("pass_floor2_up", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1000);
        applyStimulus(4'b0000, 4);
        checkOutput("door_floor3_b", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 3);
        checkOutput("idle_floor3_b", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Down to 1, then hold the floor-1 button while the door is open.
        applyStimulus(4'b0010, 1);
        checkOutput("latch_call1", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0010);
        applyStimulus(4'b0000, 9);
        checkOutput("door_floor1", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0010, 3);
        checkOutput("hold_btn_mid", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0010, 2);
        checkOutput("hold_btn_end", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 2);
        checkOutput("release_plus2", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 1);
        checkOutput("release_plus3", 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001: The block SHALL have parameter TRAVEL_CYC, default 4, giving the clock cycles to travel one floor; legal range 1..255.
REQ-002: The block SHALL have parameter DOOR_CYC, default 3, giving the clock cycles the door stays open; legal range 1..255.
REQ-003: The block SHALL have port CK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004: The block SHALL have port CLR, input, 1 bit: asynchronous active-high reset.
REQ-005: The block SHALL have port REQ, input, 4 bits: floor call buttons, bit i is floor i, sampled every rising CK edge.
REQ-006: The block SHALL have port FLOOR, output, 2 bits: current car floor.
REQ-007: The block SHALL have port UP, output, 1 bit: car moving up.
REQ-008: The block SHALL have port DOWN, output, 1 bit: car moving down.
REQ-009: The block SHALL have port DOOR_OPEN, output, 1 bit: door open at FLOOR.
REQ-010: The block SHALL have port PENDING, output, 4 bits: latched, unserved floor calls.

Function
REQ-011: All outputs SHALL be registered, or decoded from registered state only, with no combinational path from REQ.
REQ-012: The state machine SHALL have exactly four states: IDLE, MOVE_UP, MOVE_DN and DOOR; UP=1 only in MOVE_UP, DOWN=1 only in MOVE_DN, and DOOR_OPEN=1 only in DOOR.
REQ-013: PENDING[i] SHALL set on an edge where REQ[i]=1, except when i equals FLOOR and the state is, or is entering, DOOR.
REQ-014: PENDING[i] SHALL clear on the edge that enters DOOR at floor i; clear wins over a simultaneous set.
REQ-015: REQ[FLOOR]=1 while in DOOR SHALL reload the door counter to DOOR_CYC-1 and SHALL NOT latch.
REQ-016: The block SHALL hold a direction register DIR (up/down), updated on every entry to MOVE_UP or MOVE_DN.
REQ-017: In IDLE, if PENDING[FLOOR]=1, the block SHALL go to DOOR next edge.
REQ-018: In IDLE, otherwise, if a call is pending above and (DIR=up or nothing pending below), the block SHALL go to MOVE_UP.
REQ-019: In IDLE, otherwise, if a call is pending below, the block SHALL go to MOVE_DN; otherwise it SHALL stay in IDLE.
REQ-020: On entry to MOVE_*, the block SHALL load an 8-bit travel counter with TRAVEL_CYC-1 and decrement it each cycle.
REQ-021: On the edge where the travel counter is 0, FLOOR SHALL step by ±1; then, on that same edge:
- PENDING[new floor]=1 -> DOOR;
- else a call pending further in the same direction -> stay in MOVE_* with the counter reloaded;
- else -> IDLE.
REQ-022: "Pending" in REQ-021 SHALL mean the registered PENDING value before that edge.
REQ-023: FLOOR SHALL never wrap: a move is only started toward a pending floor, so 3->0 and 0->3 are impossible; MOVE_UP at floor 3 or MOVE_DN at floor 0 SHALL force IDLE.
REQ-024: On entry to DOOR, the block SHALL load a door counter with DOOR_CYC-1; at 0, DOOR SHALL go to IDLE, giving DOOR_OPEN high for exactly DOOR_CYC cycles absent reloads.
REQ-025: With TRAVEL_CYC=1 or DOOR_CYC=1, the block SHALL dwell one cycle per floor or door phase respectively.

Reset
REQ-026: CLR=1 SHALL immediately force: state IDLE, FLOOR=0, PENDING=0000, DIR=up, counters 0, UP=DOWN=DOOR_OPEN=0, independent of CK.
REQ-027: CLR asserted mid-move or mid-door SHALL abort the operation with no further state change until CLR=0.
REQ-028: The first edge after CLR deasserts SHALL sample REQ normally.

Verification
REQ-029: Defaults, floor 0, REQ=0100 for one cycle (edge 1) -> PENDING=0100 after edge 1; MOVE_UP at edge 2; FLOOR=1 at edge 6; FLOOR=2, DOOR and PENDING=0000 at edge 10; IDLE at edge 13; UP high for 8 cycles.
REQ-030: Idle at floor 0, REQ=0001 pulse -> DOOR_OPEN high for 3 cycles, no motion, PENDING[0] never set.
REQ-031: Moving up from 0 toward 3 with REQ=0010 pulsed before arrival at 1 -> stop at 1 with door for 3 cycles, then resume MOVE_UP to 3.
REQ-032: At floor 2 with DIR=up and PENDING=1001 -> go up to 3 first, then down to 0 (direction preference).
REQ-033: Door open at floor 1 with REQ=0010 held 5 cycles -> DOOR_OPEN stays high until 3 cycles after release; PENDING[1] stays 0.
REQ-034: CLR pulsed while in MOVE_DN at floor 2 with pending calls -> all outputs are reset values within the same time step; IDLE at floor 0 after release.
